// File: rtl/psg_multi.sv
// psg_multi: NUM_CH square-wave tone channels, shared 17-bit LFSR noise, per-channel mixer and amplitude.
// Define PSG_ENVELOPE_EN to build the envelope generator and its period/shape registers.
module psg_multi #(
    parameter int NUM_CH  = 3,
    parameter int TONE_W  = 12,
    parameter int CLK_DIV = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a0,
    input  logic                wr_tick,
    input  logic [7:0]          wdata,
    input  logic                rd_tick,
    output logic [7:0]          rdata,
    output logic [NUM_CH-1:0]   aout,
    output logic [4*NUM_CH-1:0] level
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [7:0] MSB_M = 8'(((32'd1 << TONE_W) - 1) >> 8);
    localparam logic [4:0] A_NOISE = 5'(2*NUM_CH);
    localparam logic [4:0] A_MIX = 5'(2*NUM_CH+1);
`ifdef PSG_ENVELOPE_EN
    localparam logic [4:0] AMP_M = 5'h1f;
`else
    localparam logic [4:0] AMP_M = 5'h0f;
`endif

    logic [4:0]          addr;
    logic [15:0]         per [NUM_CH];
    logic [15:0]         tcnt [NUM_CH];
    logic [4:0]          amp [NUM_CH];
    logic [NUM_CH-1:0]   sq;
    logic [4:0]          nper;
    logic [4:0]          ncnt;
    logic [2*NUM_CH-1:0] mix;
    logic [16:0]         lfsr;
    logic [PW-1:0]       pre;
    logic                nph;
    logic                tone_tick;
    logic                noise_tick;
    logic                wr_en;
    logic [3:0]          env_level;
    logic [7:0]          rd_val;
    logic [NUM_CH-1:0]   mixed;
    logic [4*NUM_CH-1:0] lvl;

    function automatic logic [15:0] lim(input logic [15:0] p);
        return (p == 16'd0) ? 16'd0 : p - 16'd1;
    endfunction

    assign tone_tick = pre == PW'(CLK_DIV-1);
    assign noise_tick = tone_tick & nph;
    assign wr_en = wr_tick & a0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
            nper <= '0;
            mix <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                per[c] <= '0;
                amp[c] <= '0;
            end
        end else if (wr_tick && !a0) begin
            addr <= wdata[4:0];
        end else if (wr_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (addr == 5'(2*c)) per[c][7:0] <= wdata;
                if (addr == 5'(2*c+1)) per[c][15:8] <= wdata & MSB_M;
                if (addr == 5'(2*NUM_CH+2+c)) amp[c] <= wdata[4:0] & AMP_M;
            end
            if (addr == A_NOISE) nper <= wdata[4:0];
            if (addr == A_MIX) mix <= wdata[2*NUM_CH-1:0];
        end
    end

    // Counters compare against the live period, so a lowered period wraps on the next tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
            nph <= 1'b0;
            ncnt <= '0;
            lfsr <= 17'h1;
            sq <= '0;
            for (int c = 0; c < NUM_CH; c++) tcnt[c] <= '0;
        end else begin
            pre <= tone_tick ? '0 : pre + PW'(1);
            if (tone_tick) begin
                nph <= ~nph;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (tcnt[c] >= lim(per[c])) begin
                        tcnt[c] <= '0;
                        sq[c] <= ~sq[c];
                    end else begin
                        tcnt[c] <= tcnt[c] + 16'd1;
                    end
                end
            end
            if (noise_tick) begin
                if (ncnt >= ((nper == 5'd0) ? 5'd0 : nper - 5'd1)) begin
                    ncnt <= '0;
                    lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
                end else begin
                    ncnt <= ncnt + 5'd1;
                end
            end
        end
    end

`ifdef PSG_ENVELOPE_EN
    localparam logic [4:0] A_ELO = 5'(3*NUM_CH+2);
    localparam logic [4:0] A_EHI = 5'(3*NUM_CH+3);
    localparam logic [4:0] A_SHP = 5'(3*NUM_CH+4);
    localparam logic [1:0] ST_ATT = 2'd0, ST_DEC = 2'd1, ST_HOLD = 2'd2;
    logic [15:0] eper;
    logic [15:0] ecnt;
    logic [3:0]  shape;
    logic [3:0]  step;
    logic [3:0]  hold_val;
    logic [1:0]  est;
    logic        env_wrap;

    assign env_wrap = tone_tick && (ecnt >= lim(eper));
    assign env_level = (est == ST_ATT) ? step : (est == ST_DEC) ? 4'd15 - step : hold_val;

    // shape bits: [3]=CONT [2]=ATT [1]=ALT [0]=HOLD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eper <= '0;
            ecnt <= '0;
            shape <= '0;
            step <= '0;
            hold_val <= '0;
            est <= ST_DEC;
        end else if (wr_en && addr == A_SHP) begin
            shape <= wdata[3:0];
            step <= '0;
            ecnt <= '0;
            est <= wdata[2] ? ST_ATT : ST_DEC;
        end else begin
            if (wr_en && addr == A_ELO) eper[7:0] <= wdata;
            if (wr_en && addr == A_EHI) eper[15:8] <= wdata;
            if (tone_tick) ecnt <= env_wrap ? 16'd0 : ecnt + 16'd1;
            if (env_wrap && est != ST_HOLD) begin
                step <= step + 4'd1;
                if (step == 4'd15) begin
                    if (!shape[3]) begin
                        est <= ST_HOLD;
                        hold_val <= 4'd0;
                    end else if (shape[0]) begin
                        est <= ST_HOLD;
                        hold_val <= ((est == ST_ATT) ^ shape[1]) ? 4'd15 : 4'd0;
                    end else if (shape[1]) begin
                        est <= (est == ST_ATT) ? ST_DEC : ST_ATT;
                    end
                end
            end
        end
    end
`else
    assign env_level = 4'd0;
`endif

    always_comb begin
        rd_val = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr == 5'(2*c)) rd_val = per[c][7:0];
            if (addr == 5'(2*c+1)) rd_val = per[c][15:8];
            if (addr == 5'(2*NUM_CH+2+c)) rd_val = {3'b000, amp[c]};
        end
        if (addr == A_NOISE) rd_val = {3'b000, nper};
        if (addr == A_MIX) rd_val = 8'(mix);
`ifdef PSG_ENVELOPE_EN
        if (addr == A_ELO) rd_val = eper[7:0];
        if (addr == A_EHI) rd_val = eper[15:8];
        if (addr == A_SHP) rd_val = {4'h0, shape};
`endif
    end

    always_comb begin
        mixed = '0;
        lvl = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mixed[c] = (sq[c] | mix[c]) & (lfsr[0] | mix[NUM_CH+c]);
            lvl[4*c +: 4] = mixed[c] ? (amp[c][4] ? env_level : amp[c][3:0]) : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
            aout <= '0;
            level <= '0;
        end else begin
            if (rd_tick) rdata <= rd_val;
            aout <= mixed;
            level <= lvl;
        end
    end
endmodule
